// File: rtl/avalon_mm_master.sv
// avalon_mm_master: single-outstanding Avalon-MM host turning a valid/ready command stream into read_n/write_n cycles.
// Defining AVM_MASTER_TIMEOUT_EN adds an abort after TIMEOUT_CYCLES consecutive waitrequest cycles.
module avalon_mm_master #(
   parameter int ADDR_W         = 32,
   parameter int DATA_W         = 32,
   parameter int READ_LATENCY   = 1,
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_write,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [DATA_W-1:0] cmd_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err,
   output logic [ADDR_W-1:0] address,
   output logic              read_n,
   output logic              write_n,
   output logic [DATA_W-1:0] writeData,
   input  logic              waitrequest,
   input  logic [DATA_W-1:0] readData
);

   typedef enum logic [1:0] {IDLE, ACCESS, RD_WAIT, RESP} state_t;

   state_t            state_reg, state_next;
   logic              live_reg;
   logic              write_reg;
   logic [ADDR_W-1:0] address_reg;
   logic [DATA_W-1:0] wdata_reg;
   logic [DATA_W-1:0] rdata_reg;
   logic              err_reg;
   logic [2:0]        lat_cnt_reg;
   logic              accept;
   logic              timed_out;

   assign accept    = cmd_ready && cmd_valid;
   assign address   = address_reg;
   assign writeData = wdata_reg;
   assign rsp_rdata = rdata_reg;
   assign rsp_err   = err_reg;

`ifdef AVM_MASTER_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [TO_W-1:0] stall_cnt_reg;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         stall_cnt_reg <= '0;
      else if (accept)
         stall_cnt_reg <= '0;
      else if (state_reg == ACCESS && waitrequest)
         stall_cnt_reg <= stall_cnt_reg + 1'b1;
   end

   // Abort on the edge that would record the TIMEOUT_CYCLES-th stall cycle.
   assign timed_out = (state_reg == ACCESS) && waitrequest &&
                      (stall_cnt_reg == TO_W'(TIMEOUT_CYCLES - 1));
`else
   assign timed_out = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         state_reg <= IDLE;
      else
         state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (accept) state_next = ACCESS;
         ACCESS: begin
            if (timed_out)
               state_next = RESP;
            else if (!waitrequest)
               state_next = (write_reg || READ_LATENCY == 0) ? RESP : RD_WAIT;
         end
         RD_WAIT: if (lat_cnt_reg == 3'(READ_LATENCY)) state_next = RESP;
         RESP:    if (rsp_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      cmd_ready = 1'b0;
      rsp_valid = 1'b0;
      read_n    = 1'b1;
      write_n   = 1'b1;
      case (state_reg)
         IDLE:    cmd_ready = live_reg;
         ACCESS: begin
            read_n  = write_reg;
            write_n = !write_reg;
         end
         RESP:    rsp_valid = 1'b1;
         default: ;
      endcase
   end

   // live_reg keeps cmd_ready low until the first edge after reset release.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         live_reg    <= 1'b0;
         write_reg   <= 1'b0;
         address_reg <= '0;
         wdata_reg   <= '0;
         rdata_reg   <= '0;
         err_reg     <= 1'b0;
         lat_cnt_reg <= 3'd0;
      end else begin
         live_reg <= 1'b1;
         if (accept) begin
            write_reg   <= cmd_write;
            address_reg <= cmd_addr;
            wdata_reg   <= cmd_wdata;
         end
         if (state_reg == ACCESS)
            lat_cnt_reg <= 3'd1;
         else if (state_reg == RD_WAIT)
            lat_cnt_reg <= lat_cnt_reg + 3'd1;
         if (state_reg != RESP && state_next == RESP) begin
            err_reg   <= timed_out;
            rdata_reg <= (write_reg || timed_out) ? '0 : readData;
         end
      end
   end

endmodule

// File: tb/tb_avalon_mm_master.sv
// tb_avalon_mm_master: randomized transactions against a memory-backed slave and a transaction-level response model.
// Define AVM_MASTER_TIMEOUT_EN for both files to exercise the stall-timeout path.
module tb_avalon_mm_master;
   localparam int RL = 1;
   localparam int TO = 8;

   logic        clk = 1'b0;
   logic        rst;
   logic        cmd_valid, cmd_ready, cmd_write;
   logic [31:0] cmd_addr, cmd_wdata;
   logic        rsp_valid, rsp_ready, rsp_err;
   logic [31:0] rsp_rdata;
   logic [31:0] address, writeData, readData;
   logic        read_n, write_n, waitrequest;

   int n_cmp = 0;
   int n_bad = 0;
   logic [31:0] mem [logic [31:0]];

   always #5 clk = ~clk;

   avalon_mm_master #(
      .ADDR_W(32), .DATA_W(32), .READ_LATENCY(RL), .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .address(address), .read_n(read_n), .write_n(write_n), .writeData(writeData),
      .waitrequest(waitrequest), .readData(readData)
   );

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Starts and ends at a falling edge with the DUT idle.
   task automatic run_cmd(input bit wr, input logic [31:0] a, input logic [31:0] d,
                          input int stall, input int rdly, input bit stuck);
      int k, stalls_left, strobe_cycles, bad, rd_cnt, exp_k, exp_strobes;
      logic [31:0] exp_rdata, hold_rdata;
      logic        hold_err;
      bit          exp_err;

      check_eq("cmd_ready_idle", cmd_ready, 1);
      exp_err = stuck;
      if (stuck)
         exp_rdata = 32'h0;
      else if (wr)
         exp_rdata = 32'h0;
      else
         exp_rdata = mem.exists(a) ? mem[a] : 32'h0;
      if (wr && !stuck) mem[a] = d;

      cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d; rsp_ready = 1'b1;
      @(posedge clk);
      k = 0; stalls_left = stall; strobe_cycles = 0; bad = 0; rd_cnt = -1;
      while (k < 200) begin
         @(negedge clk);
         cmd_valid = 1'b0;
         cmd_addr  = $urandom;
         waitrequest = 1'b0;
         readData    = $urandom;
         if (rsp_valid) break;
         if (cmd_ready) bad++;
         if (rd_cnt > 0) rd_cnt--;
         if (!read_n || !write_n) begin
            strobe_cycles++;
            if (wr ? (write_n !== 1'b0 || read_n !== 1'b1) : (read_n !== 1'b0 || write_n !== 1'b1)) bad++;
            if (address !== a || (wr && writeData !== d)) bad++;
            if (stuck || stalls_left > 0) begin
               waitrequest = 1'b1;
               stalls_left--;
            end else if (!wr) begin
               rd_cnt = RL;
            end
         end
         if (rd_cnt == 0) begin
            readData = exp_rdata;
            rd_cnt = -1;
         end
         @(posedge clk);
         k++;
      end

      exp_k       = stuck ? TO : 1 + stall + (wr ? 0 : RL);
      exp_strobes = stuck ? TO : 1 + stall;
      check_eq("rsp_latency", k, exp_k);
      check_eq("strobe_cycles", strobe_cycles, exp_strobes);
      check_eq("bus_protocol", bad, 0);
      check_eq("rsp_rdata", rsp_rdata, exp_rdata);
      check_eq("rsp_err", rsp_err, exp_err);
      $display("txn %s addr=0x%08h wdata=0x%08h stall=%0d stuck=%0d rdly=%0d -> rdata=0x%08h err=%0d lat=%0d",
               wr ? "WR" : "RD", a, d, stall, stuck, rdly, rsp_rdata, rsp_err, k);

      hold_rdata = rsp_rdata; hold_err = rsp_err; bad = 0;
      for (int i = 0; i < rdly; i++) begin
         rsp_ready = 1'b0;
         cmd_valid = 1'b1; cmd_write = 1'($urandom); cmd_addr = $urandom; cmd_wdata = $urandom;
         @(posedge clk);
         @(negedge clk);
         if (rsp_valid !== 1'b1 || rsp_rdata !== hold_rdata || rsp_err !== hold_err) bad++;
         if (cmd_ready !== 1'b0 || read_n !== 1'b1 || write_n !== 1'b1) bad++;
      end
      check_eq("backpressure_hold", bad, 0);

      rsp_ready = 1'b1; cmd_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check_eq("post_hs_rsp_valid", rsp_valid, 0);
      check_eq("post_hs_cmd_ready", cmd_ready, 1);
   endtask

   task automatic mid_reset();
      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h8; waitrequest = 1'b1; rsp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      cmd_valid = 1'b0;
      check_eq("midrst_strobe_active", read_n, 0);
      #2 rst = 1'b0;
      #1;
      check_eq("midrst_read_n", read_n, 1);
      check_eq("midrst_write_n", write_n, 1);
      check_eq("midrst_cmd_ready", cmd_ready, 0);
      check_eq("midrst_rsp_valid", rsp_valid, 0);
      @(negedge clk);
      rst = 1'b1; waitrequest = 1'b0;
      @(negedge clk);
      check_eq("midrst_ready_after", cmd_ready, 1);
      check_eq("midrst_no_rsp", rsp_valid, 0);
      $display("txn RESET during read access");
   endtask

   initial begin
      rst = 1'b0;
      cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h44; cmd_wdata = 32'hDEAD_BEEF;
      rsp_ready = 1'b0; waitrequest = 1'b0; readData = 32'h0;
      repeat (3) @(negedge clk);
      check_eq("rst_read_n", read_n, 1);
      check_eq("rst_write_n", write_n, 1);
      check_eq("rst_cmd_ready", cmd_ready, 0);
      check_eq("rst_rsp_valid", rsp_valid, 0);
      check_eq("rst_rsp_err", rsp_err, 0);
      check_eq("rst_rsp_rdata", rsp_rdata, 0);
      check_eq("rst_address", address, 0);
      check_eq("rst_writeData", writeData, 0);
      cmd_valid = 1'b0;
      rst = 1'b1;
      #1;
      check_eq("release_cmd_ready_low", cmd_ready, 0);
      @(negedge clk);
      check_eq("release_cmd_ready", cmd_ready, 1);

      mem[32'h20] = 32'h1234_5678;
      run_cmd(1'b1, 32'h10, 32'hA5A5_0001, 0, 0, 1'b0);
      run_cmd(1'b0, 32'h20, 32'h0, 0, 0, 1'b0);
      run_cmd(1'b1, 32'h30, 32'hCAFE_0030, 5, 0, 1'b0);
      run_cmd(1'b0, 32'h10, 32'h0, 0, 4, 1'b0);
`ifdef AVM_MASTER_TIMEOUT_EN
      run_cmd(1'b0, 32'h20, 32'h0, 0, 0, 1'b1);
      run_cmd(1'b0, 32'h20, 32'h0, 0, 0, 1'b0);
`endif
      mid_reset();
      run_cmd(1'b0, 32'h30, 32'h0, 1, 0, 1'b0);

      for (int t = 0; t < 40; t++) begin
         bit          wr;
         logic [31:0] a;
         wr = 1'($urandom_range(0, 1));
         a  = 32'($urandom_range(0, 15)) << 2;
         run_cmd(wr, a, $urandom, ($urandom_range(0, 3) == 0) ? $urandom_range(1, 5) : 0,
                 $urandom_range(0, 3), 1'b0);
         if ($urandom_range(0, 3) == 0) begin
            rsp_ready = 1'b1; cmd_valid = 1'b0;
            @(posedge clk);
            @(negedge clk);
            check_eq("idle_rsp_ready_quiet", {rsp_valid, read_n, write_n}, 3'b011);
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, %0d compared / %0d mismatched", n_cmp, n_bad);
      $fatal(1);
   end
endmodule
